tinker_io_port: RTL
===================

# tinker_io_port

Responder for the CPU's IN/OUT port strobes. Buffers host-supplied input words in an RX FIFO and presents the head to the CPU on `in_data`. Captures CPU output words into a TX FIFO that the host drains through a valid/ready stream. Sits beside `ram` under the top level: the CPU is on one side and the testbench/host on the other.

## Interface
Parameters:
- `DEPTH`, 8, entries per FIFO; power of two, ≥2
- `WIDTH`, 64, word width; matches CPU `in_data`/`out_data`

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  reset, asynchronous, active-low
- `in_signal`  in  1  CPU IN strobe; each high cycle pops one RX word
- `in_data`  out  WIDTH  RX FIFO head, or 0 when empty
- `out_signal`  in  1  CPU OUT strobe; each high cycle pushes `out_data`
- `out_data`  in  WIDTH  CPU output word
- `rx_valid`  in  1  host input word valid
- `rx_ready`  out  1  RX FIFO can accept
- `rx_data`  in  WIDTH  host input word
- `tx_valid`  out  1  TX FIFO non-empty
- `tx_ready`  in  1  host accepts TX head
- `tx_data`  out  WIDTH  TX FIFO head
- `rx_count`, `tx_count`  out  $clog2(DEPTH)+1  occupancy
- `err_clr`  in  1  clears sticky error flags
- `underflow`, `overflow`  out  1  sticky flags
- `error`  out  1  `underflow | overflow`

## Operation
- RX push: `rx_valid && rx_ready`. `rx_ready` = !rx_full, and is forced to 0 while `reset` is low.
- RX pop: `in_signal` high.
  - Non-empty: pop the head.
  - Empty: no pop, `in_data` stays 0, set `underflow`.
- TX push: `out_signal` high.
  - Not full: push `out_data`.
  - Full: drop the word and set `overflow`. This applies unless a host pop occurs the same cycle, in which case the push is accepted.
- TX pop: `tx_valid && tx_ready`.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged. This holds at full only for TX, because `rx_ready` is already 0 when RX is full.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. The count holds 0..DEPTH inclusive.
- Sticky flags:
  - Set by the events above.
  - Cleared by `err_clr` when no new set event occurs that cycle. A set event in the same cycle wins.
- The state per FIFO is implicit: EMPTY (count 0), PARTIAL, FULL (count DEPTH). There is no other FSM.

## Timing
- All outputs are registered or derived from registered state. There is no combinational path from any input to any output, except the `rx_ready` reset gating.
- Latency:
  - An RX word pushed at edge N appears on `in_data` after edge N (visible in cycle N+1).
  - A CPU OUT at edge N raises `tx_valid` in cycle N+1.
- Values while `reset` is low: all pointers/counts 0, `in_data` 0, `tx_valid` 0, `tx_data` 0, `rx_ready` 0, flags 0.
- Reset asserted mid-transfer: in-flight FIFO contents are discarded, with no partial word.
- `rx_ready` rises in the first cycle after `reset` deasserts.

## Configuration
- `TINKER_IO_LOOPBACK_EN`
  - Defined: adds input port `loopback` (1 bit).
    - When `loopback` is high, the TX FIFO head is moved into the RX FIFO whenever TX is non-empty and RX is not full. One word moves per cycle.
    - `tx_valid` is 0 in this mode, and host `rx_valid` is ignored (`rx_ready` 0).
  - Undefined: no `loopback` port. TX and RX are always host-connected.

## Structure
- Package `tinker_io_pkg` holds:
  - `IO_WORD_W = 64`
  - `IO_DEPTH_DEF = 8`
  - typedef `io_word_t`
  - a function returning the count width for a given depth
- One sub-module, `io_fifo`, instantiated twice (RX, TX):
  - synchronous FIFO with push/pop/full/empty/count and registered head
  - same clock and async active-low reset

## Test plan
- Reset: hold `reset` low 3 cycles with `rx_valid`=1 → `rx_ready`=0, `in_data`=0, `tx_valid`=0. After release, `rx_ready`=1 next cycle.
- RX order: host pushes 0x11, 0x22, 0x33 → `in_data`=0x11. Three single-cycle `in_signal` pulses yield 0x11, 0x22, 0x33, then `rx_count`=0, `in_data`=0.
- RX underflow: `in_signal` with RX empty → `underflow`=1 and `error`=1, held until `err_clr`. Then `err_clr` with a simultaneous new underflow → flag stays 1.
- TX full: with `tx_ready`=0, 9 OUT pulses of 1..9 (DEPTH 8) → `tx_count`=8, `overflow`=1. Host drains 1..8; 9 is dropped.
- TX full with simultaneous pop: TX full, `tx_ready`=1 and `out_signal`=1 with 0xAA in the same cycle → no overflow, count stays 8, 0xAA is last out.
- Loopback (macro defined, `loopback`=1): OUT 0x5A → `in_data`=0x5A within 2 cycles, `tx_valid` never asserts.

Source files
------------

// File: rtl/tinker_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tinker_io_pkg
//  Description : Shared constants, word type and sizing helper for the
//                tinker IN/OUT port responder and its FIFOs.
//  Revision    : 1.0 - initial release
// ============================================================================
package tinker_io_pkg;

   localparam int IO_WORD_W    = 64;
   localparam int IO_DEPTH_DEF = 8;

   typedef logic [IO_WORD_W-1:0] io_word_t;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int io_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/io_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : io_fifo
//  Description : Synchronous FIFO with push/pop, full/empty, occupancy count
//                and a registered head word (head reads 0 while empty).
//  Revision    : 1.0 - initial release
// ============================================================================
module io_fifo
   import tinker_io_pkg::*;
#(
   parameter int DEPTH = IO_DEPTH_DEF,
   parameter int WIDTH = IO_WORD_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic                          full,
   output logic                          empty,
   output logic [io_cnt_w(DEPTH)-1:0]    count,
   output logic [WIDTH-1:0]              head
);

   localparam int                 c_PTR_W    = $clog2(DEPTH);
   localparam int                 c_CNT_W    = io_cnt_w(DEPTH);
   localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
   localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic [WIDTH-1:0]   r_head;

   logic               w_empty;
   logic               w_full;
   logic               w_do_push;
   logic               w_do_pop;
   logic [c_PTR_W-1:0] w_rd_ptr_inc;
   logic [c_CNT_W-1:0] w_count_nxt;
   logic [WIDTH-1:0]   w_head_nxt;

   assign w_empty      = (r_count == '0);
   assign w_full       = (r_count == c_FULL_CNT);
   assign w_rd_ptr_inc = r_rd_ptr + c_PTR_ONE;

   // A pop frees a slot in the same cycle, so a push at full is accepted
   // only when paired with a real pop.
   assign w_do_pop  = pop && !w_empty;
   assign w_do_push = push && (!w_full || w_do_pop);

   // Next occupancy and next head word, computed from the post-edge contents.
   always_comb begin
      w_count_nxt = r_count;
      w_head_nxt  = r_head;
      case ({w_do_push, w_do_pop})
         2'b10:   w_count_nxt = r_count + c_ONE;
         2'b01:   w_count_nxt = r_count - c_ONE;
         default: w_count_nxt = r_count;
      endcase
      if (w_count_nxt == '0) begin
         w_head_nxt = '0;
      end else if (w_do_pop) begin
         // With a single entry left the only survivor is the incoming word.
         w_head_nxt = (r_count == c_ONE) ? push_data : r_mem[w_rd_ptr_inc];
      end else if (w_empty) begin
         w_head_nxt = push_data;
      end
   end

   // Storage array; contents need no reset because pointers/count gate them.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointer, count and head registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_head   <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_do_pop)  r_rd_ptr <= w_rd_ptr_inc;
         r_count <= w_count_nxt;
         r_head  <= w_head_nxt;
      end
   end

   assign full  = w_full;
   assign empty = w_empty;
   assign count = r_count;
   assign head  = r_head;

endmodule
`default_nettype wire

// File: rtl/tinker_io_port.sv
`default_nettype none
// ============================================================================
//  Module      : tinker_io_port
//  Description : CPU IN/OUT strobe responder. Host words enter an RX FIFO
//                whose head feeds the CPU; CPU OUT words enter a TX FIFO the
//                host drains over a valid/ready stream. Sticky underflow and
//                overflow flags. Optional macro TINKER_IO_LOOPBACK_EN adds a
//                'loopback' input that routes TX words straight into RX.
//  Revision    : 1.0 - initial release
// ============================================================================
module tinker_io_port
   import tinker_io_pkg::*;
#(
   parameter int DEPTH = IO_DEPTH_DEF,
   parameter int WIDTH = IO_WORD_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_signal,
   output logic [WIDTH-1:0]           in_data,
   input  logic                       out_signal,
   input  logic [WIDTH-1:0]           out_data,
   input  logic                       rx_valid,
   output logic                       rx_ready,
   input  logic [WIDTH-1:0]           rx_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic [WIDTH-1:0]           tx_data,
   output logic [io_cnt_w(DEPTH)-1:0] rx_count,
   output logic [io_cnt_w(DEPTH)-1:0] tx_count,
`ifdef TINKER_IO_LOOPBACK_EN
   input  logic                       loopback,
`endif
   input  logic                       err_clr,
   output logic                       underflow,
   output logic                       overflow,
   output logic                       error
);

   logic             w_lb;
   logic             w_lb_move;
   logic             w_rx_full;
   logic             w_rx_empty;
   logic             w_tx_full;
   logic             w_tx_empty;
   logic             w_rx_push;
   logic [WIDTH-1:0] w_rx_din;
   logic             w_tx_pop;
   logic             w_uf_set;
   logic             w_of_set;
   logic             r_underflow;
   logic             r_overflow;

`ifdef TINKER_IO_LOOPBACK_EN
   assign w_lb = loopback;
`else
   assign w_lb = 1'b0;
`endif

   // In loopback the host side is cut off and one TX word moves per cycle.
   assign w_lb_move = w_lb && !w_tx_empty && !w_rx_full;
   assign rx_ready  = reset && !w_rx_full && !w_lb;
   assign tx_valid  = !w_tx_empty && !w_lb;
   assign w_rx_push = w_lb ? w_lb_move : (rx_valid && rx_ready);
   assign w_rx_din  = w_lb ? tx_data : rx_data;
   assign w_tx_pop  = w_lb ? w_lb_move : (tx_valid && tx_ready);

   // A full-TX OUT is only lost when no pop frees a slot that cycle.
   assign w_uf_set = in_signal && w_rx_empty;
   assign w_of_set = out_signal && w_tx_full && !w_tx_pop;

   io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (w_rx_push),
      .push_data (w_rx_din),
      .pop       (in_signal),
      .full      (w_rx_full),
      .empty     (w_rx_empty),
      .count     (rx_count),
      .head      (in_data)
   );

   io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (out_signal),
      .push_data (out_data),
      .pop       (w_tx_pop),
      .full      (w_tx_full),
      .empty     (w_tx_empty),
      .count     (tx_count),
      .head      (tx_data)
   );

   // Sticky error flags; a new set event beats a same-cycle clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_uf_set)     r_underflow <= 1'b1;
         else if (err_clr) r_underflow <= 1'b0;
         if (w_of_set)     r_overflow  <= 1'b1;
         else if (err_clr) r_overflow  <= 1'b0;
      end
   end

   assign underflow = r_underflow;
   assign overflow  = r_overflow;
   assign error     = r_underflow | r_overflow;

endmodule
`default_nettype wire
